// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
//   Registered, rate-limited driver for NUM_DIGITS seven-segment hex digits
//   with active-low segments. A captured value is committed to the display at
//   most once per UPDATE_DIV cycles, so fast-changing debug values stay
//   readable. Also provides leading-zero blanking, a per-digit blink mask and
//   a hold/freeze control.
//
// Ports
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   data_in    : value to display, nibble k drives digit k (digit 0 = LSD)
//   data_valid : one-cycle capture strobe for data_in
//   hold       : 1 = freeze the displayed value (captures still go to pending)
//   blank_lz   : 1 = blank leading zero digits (digit 0 always shown)
//   blink_mask : bit k = 1 makes digit k blink
//   hex_out    : segments {g..a} per digit, digit k at [7k+6:7k], 0 = lit
//   updated    : one-cycle pulse when a new value is committed
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int UPDATE_DIV = 12_500_000,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic                      data_valid,
  input  logic                      hold,
  input  logic                      blank_lz,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [7*NUM_DIGITS-1:0]   hex_out,
  output logic                      updated
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int SW    = 7 * NUM_DIGITS;
  localparam int UPD_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPDATE_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [UPD_W-1:0] upd_cnt_reg;
  logic [BLK_W-1:0] blink_cnt_reg;
  logic             blink_phase_reg;
  logic             pending_reg;
  logic [DW-1:0]    pending_data_reg;
  logic [DW-1:0]    shown_reg;
  logic             updated_reg;
  logic [SW-1:0]    hex_out_reg;

  logic             tick;
  logic             commit;
  logic [SW-1:0]    hex_next;
  logic [NUM_DIGITS-1:0] lz_dark;
  logic             zero_run;

  assign tick   = (upd_cnt_reg == UPD_LAST);
  // A valid arriving in the tick cycle commits directly, bypassing pending.
  assign commit = tick & ~hold & (pending_reg | data_valid);

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0011000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Walk from the most significant digit down: a digit is a leading zero
  // while every nibble from it upward is zero. Digit 0 is never blanked.
  always_comb begin
    zero_run = 1'b1;
    lz_dark  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run & (shown_reg[4*k +: 4] == 4'h0);
      lz_dark[k] = blank_lz & zero_run & (k != 0);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign hex_next[7*gi +: 7] =
        (lz_dark[gi] | (blink_mask[gi] & ~blink_phase_reg))
          ? 7'b1111111 : glyph(shown_reg[4*gi +: 4]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_cnt_reg      <= '0;
      blink_cnt_reg    <= '0;
      blink_phase_reg  <= 1'b1;
      pending_reg      <= 1'b0;
      pending_data_reg <= '0;
      shown_reg        <= '0;
      updated_reg      <= 1'b0;
      hex_out_reg      <= '1;
    end else begin
      upd_cnt_reg <= tick ? '0 : upd_cnt_reg + UPD_W'(1);

      if (blink_cnt_reg == BLK_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLK_W'(1);
      end

      if (data_valid) begin
        pending_data_reg <= data_in;
      end

      if (commit) begin
        pending_reg <= 1'b0;
        shown_reg   <= data_valid ? data_in : pending_data_reg;
      end else if (data_valid) begin
        pending_reg <= 1'b1;
      end

      updated_reg <= commit;
      hex_out_reg <= hex_next;
    end
  end

  assign hex_out = hex_out_reg;
  assign updated = updated_reg;

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

  localparam int ND = 6;

  logic clk = 1'b0;
  logic reset;

  // DUT A: UPDATE_DIV=4, BLINK_DIV=3
  logic [4*ND-1:0] a_data;
  logic            a_valid, a_hold, a_blank_lz;
  logic [ND-1:0]   a_mask;
  logic [7*ND-1:0] a_hex;
  logic            a_upd;

  // DUT B: UPDATE_DIV=1 (tick every cycle)
  logic [4*ND-1:0] b_data;
  logic            b_valid, b_hold, b_blank_lz;
  logic [ND-1:0]   b_mask;
  logic [7*ND-1:0] b_hex;
  logic            b_upd;

  hex_display_ctrl #(.NUM_DIGITS(ND), .UPDATE_DIV(4), .BLINK_DIV(3)) dut_a (
    .clk(clk), .reset(reset), .data_in(a_data), .data_valid(a_valid),
    .hold(a_hold), .blank_lz(a_blank_lz), .blink_mask(a_mask),
    .hex_out(a_hex), .updated(a_upd)
  );

  hex_display_ctrl #(.NUM_DIGITS(ND), .UPDATE_DIV(1), .BLINK_DIV(3)) dut_b (
    .clk(clk), .reset(reset), .data_in(b_data), .data_valid(b_valid),
    .hold(b_hold), .blank_lz(b_blank_lz), .blink_mask(b_mask),
    .hex_out(b_hex), .updated(b_upd)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Cycles since reset release (value equals DUT A's upd_cnt modulo 4).
  int cyc;
  // Reference blink phase for BLINK_DIV=3; m_phase_d is the phase that the
  // current hex_out value was computed from.
  int   m_cnt;
  logic m_phase, m_phase_d;

  always @(posedge clk) begin
    if (reset) begin
      cyc <= 0; m_cnt <= 0; m_phase <= 1'b1; m_phase_d <= 1'b1;
    end else begin
      cyc       <= cyc + 1;
      m_phase_d <= m_phase;
      if (m_cnt == 2) begin m_cnt <= 0; m_phase <= ~m_phase; end
      else m_cnt <= m_cnt + 1;
    end
  end

  // Scoreboards: expected hex_out per committed value.
  logic [7*ND-1:0] qa[$];
  logic [7*ND-1:0] qb[$];
  logic [7*ND-1:0] exp_a_cur, exp_b_cur;
  logic chk_a = 1'b0, chk_b = 1'b0;
  int upd_a_cnt = 0, upd_b_cnt = 0;

  always @(negedge clk) begin
    if (chk_a) begin
      check("a_hex_after_commit", 64'(a_hex), 64'(exp_a_cur));
      $display("A commit displayed hex_out=%h", a_hex);
      chk_a = 1'b0;
    end
    if (!reset && a_upd) begin
      upd_a_cnt++;
      if (qa.size() == 0) begin
        check("a_unexpected_update", 64'(1), 64'(0));
      end else begin
        exp_a_cur = qa.pop_front();
        chk_a = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_b) begin
      check("b_hex_after_commit", 64'(b_hex), 64'(exp_b_cur));
      $display("B commit displayed hex_out=%h", b_hex);
      chk_b = 1'b0;
    end
    if (!reset && b_upd) begin
      upd_b_cnt++;
      if (qb.size() == 0) begin
        check("b_unexpected_update", 64'(1), 64'(0));
      end else begin
        exp_b_cur = qb.pop_front();
        chk_b = 1'b1;
      end
    end
  end

  // Called at a negedge; leaves valid low at the following negedge.
  task automatic issue_a(input logic [4*ND-1:0] d);
    a_data = d; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Wait (bounded) until DUT A's update counter will be 'target' at next edge.
  task automatic wait_cnt(input int target);
    int ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((cyc % 4) == target) begin ok = 1; break; end
    end
    if (ok == 0) check("wait_cnt_timeout", 64'(0), 64'(1));
  endtask

  localparam logic [6:0] DK = 7'b1111111;
  localparam logic [6:0] G0 = 7'b1000000;

  logic [7*ND-1:0] e;
  logic [6:0]      d0;

  initial begin
    reset = 1'b1;
    a_data = '0; a_valid = 1'b0; a_hold = 1'b0; a_blank_lz = 1'b0; a_mask = '0;
    b_data = '0; b_valid = 1'b0; b_hold = 1'b0; b_blank_lz = 1'b0; b_mask = '0;
    wait_cycles(3);
    check("reset_a_hex", 64'(a_hex), 64'(42'h3FF_FFFF_FFFF));
    check("reset_a_upd", 64'(a_upd), 64'(0));
    check("reset_b_hex", 64'(b_hex), 64'(42'h3FF_FFFF_FFFF));
    check("reset_b_upd", 64'(b_upd), 64'(0));
    reset = 1'b0;
    wait_cycles(6);
    check("no_update_without_valid", 64'(upd_a_cnt), 64'(0));

    // 12AB3F, no blanking
    wait_cnt(0);
    e = {7'b1111001, 7'b0100100, 7'b0001000, 7'b0000011, 7'b0110000, 7'b0001110};
    qa.push_back(e);
    issue_a(24'h12AB3F);
    wait_cycles(6);
    check("a_upd_count_1", 64'(upd_a_cnt), 64'(1));

    // Two valids before the tick: last wins, single commit, blanked "40"
    wait_cnt(0);
    a_blank_lz = 1'b1;
    e = {DK, DK, DK, DK, 7'b0011001, G0};
    qa.push_back(e);
    issue_a(24'h000001);
    issue_a(24'h000040);
    wait_cycles(6);
    check("a_upd_count_2", 64'(upd_a_cnt), 64'(2));

    // Zero with blanking shows only digit 0
    wait_cnt(0);
    e = {DK, DK, DK, DK, DK, G0};
    qa.push_back(e);
    issue_a(24'h000000);
    wait_cycles(6);
    check("a_upd_count_3", 64'(upd_a_cnt), 64'(3));

    // Blink digit 0 showing 5
    wait_cnt(0);
    e = {DK, DK, DK, DK, DK, 7'b0010010};
    qa.push_back(e);
    issue_a(24'h000005);
    wait_cycles(6);
    check("a_queue_drained", 64'(qa.size()), 64'(0));
    a_mask = 6'b000001;
    wait_cycles(2);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      d0 = m_phase_d ? 7'b0010010 : DK;
      e = {DK, DK, DK, DK, DK, d0};
      check("a_blink", 64'(a_hex), 64'(e));
      $display("blink cycle %0d hex_out=%h", i, a_hex);
    end

    // Reset mid-blink with a pending value: value discarded, phase on
    wait_cnt(0);
    issue_a(24'h000009);
    reset = 1'b1;
    wait_cycles(2);
    check("midreset_hex", 64'(a_hex), 64'(42'h3FF_FFFF_FFFF));
    check("midreset_upd", 64'(a_upd), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    e = {DK, DK, DK, DK, DK, G0};
    check("after_reset_phase_on", 64'(a_hex), 64'(e));
    a_mask = '0;
    wait_cycles(8);
    check("pending_discarded_hex", 64'(a_hex), 64'(e));
    check("pending_discarded_upd", 64'(upd_a_cnt), 64'(4));

    // DUT B: UPDATE_DIV=1, valid coincident with tick
    e = {G0, G0, 7'b1000110, G0, 7'b0100001, 7'b0000110};
    qb.push_back(e);
    b_data = 24'h00C0DE; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    check("b_updated_next_cycle", 64'(b_upd), 64'(1));
    @(negedge clk);
    check("b_hex_two_cycles", 64'(b_hex), 64'(e));

    // Hold blocks commit; release commits at the next tick
    b_hold = 1'b1;
    b_data = 24'h00000F; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    wait_cycles(5);
    check("b_hold_hex_frozen", 64'(b_hex), 64'(e));
    check("b_hold_no_update", 64'(upd_b_cnt), 64'(1));
    qb.push_back({G0, G0, G0, G0, G0, 7'b0001110});
    b_hold = 1'b0;
    wait_cycles(3);
    check("b_upd_after_hold", 64'(upd_b_cnt), 64'(2));
    check("b_queue_drained", 64'(qb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
